// File: rtl/pipeline_issue_ctrl.sv
// Issue/stall controller for the 5-stage ALU pipeline: per-register pending-write scoreboard,
// RAW/WAW stall generation and start/done sequencing of the shared multi-cycle MUL/DIV unit.
module pipeline_issue_ctrl #(
    parameter  int NREG       = 16,
    parameter  int WB_BYPASS  = 1,
    parameter  int MD_TIMEOUT = 64,
    parameter  int CNT_W      = 16,
    localparam int RW         = $clog2(NREG),
    localparam int TMO_W      = $clog2(MD_TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic             wb_valid,
    input  logic [RW-1:0]    wb_rd,
    input  logic             md_done,
    output logic             issue,
    output logic             stall,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_err,
    output logic [NREG-1:0]  pend_mask,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    md_state_e        state_q, state_d;
    logic [NREG-1:0]  pend_q, pend_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [RW-1:0]    md_dest_q, md_dest_d;
    logic             md_err_q, md_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             rs_rdy, rt_rdy, op_md, op_legal, tmo_hit;

    // Same-cycle issue decision; a writeback this cycle makes its register ready when bypassing.
    always_comb begin
        op_md    = (id_opcode == 4'd2) || (id_opcode == 4'd3);
        op_legal = (id_opcode <= 4'd3);
        rs_rdy   = ~pend_q[id_rs] | ((WB_BYPASS != 0) & wb_valid & (wb_rd == id_rs));
        rt_rdy   = ~pend_q[id_rt] | ((WB_BYPASS != 0) & wb_valid & (wb_rd == id_rt));
        if (rst) begin
            issue    = 1'b0;
            stall    = 1'b0;
            md_start = 1'b0;
        end else begin
            issue    = id_valid & rs_rdy & rt_rdy & ~(op_md & md_busy);
            stall    = id_valid & ~issue;
            md_start = issue & op_md;
        end
    end

    // MD sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MD sequencer next state; md_done while idle is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start) state_d = MD_RUN;
                else          state_d = MD_IDLE;
            end
            MD_RUN: begin
                if (md_done || tmo_hit) state_d = MD_IDLE;
                else                    state_d = MD_RUN;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // MD sequencer outputs; a done arriving on the last allowed cycle is a normal completion.
    always_comb begin
        md_busy = (state_q == MD_RUN);
        tmo_hit = md_busy & ~md_done & (tmo_q == TMO_W'(MD_TIMEOUT - 1));
    end

    // Scoreboard, timeout counter, error flag and stall counter next values.
    always_comb begin
        pend_d = pend_q;
        if (wb_valid) begin
            pend_d[wb_rd] = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (tmo_hit) begin
            pend_d[md_dest_q] = 1'b0;
        end else begin
            pend_d = pend_d;
        end
        // Applied last so a set beats a clear of the same register in the same cycle.
        if (issue && op_legal) begin
            pend_d[id_rs] = 1'b1;
        end else begin
            pend_d = pend_d;
        end

        if (md_busy) tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        else         tmo_d = {TMO_W{1'b0}};

        if (md_start) md_dest_d = id_rs;
        else          md_dest_d = md_dest_q;

        md_err_d = md_err_q | tmo_hit;

        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= {NREG{1'b0}};
            tmo_q       <= {TMO_W{1'b0}};
            md_dest_q   <= {RW{1'b0}};
            md_err_q    <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pend_q      <= pend_d;
            tmo_q       <= tmo_d;
            md_dest_q   <= md_dest_d;
            md_err_q    <= md_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pend_mask = pend_q;
    assign md_err    = md_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule
